temp_calc_seq: RTL and testbench

- Sequential, parametrised successor to the combinational temperature calculator.
- Computes tempc = tc_base ± ((tc_ref² × |adc|) >> SHIFT), where the sign of the correction comes from the ADC MSB.
- Uses an iterative shift-add datapath and a valid/ready handshake on both sides.
- Carries a channel tag so one instance can be time-shared across NCH sensors, and adds overflow detection with an optional saturation mode.

---
 rtl/temp_calc_seq.sv | 190 +++++++++++++++++++
 tb/tb_temp_calc_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_calc_seq.sv
// Sequential temperature calculator: tempc = base +/- ((ref^2 * |adc|) >> SHIFT),
// computed with an iterative shift-add datapath behind valid/ready handshakes.
module temp_calc_seq #(
  parameter int ADC_W = 16,
  parameter int REF_W = 8,
  parameter int OUT_W = 32,
  parameter int SHIFT = 6,
  parameter int NCH   = 4,
  parameter int SAT   = 0,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [OUT_W-1:0] tc_base,
  input  logic [REF_W-1:0] tc_ref,
  input  logic [ADC_W-1:0] adc_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_ch,
  output logic [OUT_W-1:0] tempc,
  output logic             ovf,
  output logic [2:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends combinationally on ready, and held outputs stay stable until taken.

  localparam int P_W   = 2 * REF_W + ADC_W - 1;
  localparam int MAG_W = ADC_W - 1;
  localparam int MPL_W = (REF_W > MAG_W) ? REF_W : MAG_W;
  localparam int CNT_W = $clog2(MPL_W + 1);
  localparam int MAXW  = (P_W > OUT_W) ? P_W : OUT_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SQ   = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [OUT_W-1:0] base_q, base_d;
  logic             sign_q, sign_d;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic [MPL_W-1:0] mplier_q, mplier_d;
  logic [P_W-1:0]   mcand_q, mcand_d;
  logic [P_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0] tempc_q, tempc_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [P_W-1:0]   step_sum;
  logic [P_W-1:0]   shifted;
  logic [MAXW-1:0]  wide;
  logic [OUT_W-1:0] corr;
  logic [OUT_W-1:0] res;
  logic             res_ovf;

  assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign shifted  = acc_q >> SHIFT;
  assign wide     = MAXW'(shifted);
  assign corr     = wide[OUT_W-1:0];
  assign res      = sign_q ? (base_q - corr) : (base_q + corr);

  // Overflow direction always follows the sign of the base operand.
  always_comb begin
    if (sign_q) begin
      res_ovf = (base_q[OUT_W-1] != corr[OUT_W-1]) && (res[OUT_W-1] != base_q[OUT_W-1]);
    end else begin
      res_ovf = (base_q[OUT_W-1] == corr[OUT_W-1]) && (res[OUT_W-1] != base_q[OUT_W-1]);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    base_d      = base_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    mplier_d    = mplier_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    tempc_d     = tempc_q;
    out_ch_d    = out_ch_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ch_d     = in_ch;
          base_d   = tc_base;
          sign_d   = adc_data[ADC_W-1];
          mag_d    = adc_data[ADC_W-2:0];
          mplier_d = MPL_W'(tc_ref);
          mcand_d  = P_W'(tc_ref);
          acc_d    = '0;
          cnt_d    = CNT_W'(REF_W - 1);
          state_d  = S_SQ;
        end
      end
      S_SQ: begin
        acc_d    = step_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          // The finished square becomes the multiplicand for the magnitude pass.
          mcand_d  = step_sum;
          mplier_d = MPL_W'(mag_q);
          acc_d    = '0;
          cnt_d    = CNT_W'(MAG_W - 1);
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        acc_d    = step_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        ovf_d = res_ovf;
        if ((SAT != 0) && res_ovf) begin
          tempc_d = base_q[OUT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
          tempc_d = res;
        end
        out_ch_d    = ch_q;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ch_q        <= '0;
      base_q      <= '0;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      mplier_q    <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      tempc_q     <= '0;
      out_ch_q    <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      base_q      <= base_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      mplier_q    <= mplier_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      tempc_q     <= tempc_d;
      out_ch_q    <= out_ch_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign tempc     = tempc_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_temp_calc_seq.sv
// Bench for temp_calc_seq: random and directed requests against an arithmetic reference,
// with a wrap-mode and a saturating instance driven in parallel.
module tb_temp_calc_seq;

  localparam int LAT   = 24;
  localparam int EXP_W = 99;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_ch = '0;
  logic [31:0] tc_base = '0;
  logic [7:0]  tc_ref = '0;
  logic [15:0] adc_data = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, ovf;
  logic [1:0]  out_ch;
  logic [31:0] tempc;
  logic [2:0]  dbg_state;
  logic        s_in_ready, s_out_valid, s_ovf;
  logic [1:0]  s_out_ch;
  logic [31:0] s_tempc;
  logic [2:0]  s_dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rise_cyc = 0;
  logic prev_v = 1'b0;
  logic rdy_mode = 1'b0;
  logic rdy_fixed = 1'b1;

  // {accept cycle, ch, ovf, saturated result, wrapped result}
  logic [EXP_W-1:0] exp_q[$];

  temp_calc_seq #(.SAT(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .tc_base(tc_base), .tc_ref(tc_ref), .adc_data(adc_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch), .tempc(tempc), .ovf(ovf), .dbg_state(dbg_state)
  );

  temp_calc_seq #(.SAT(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_ch(in_ch),
    .tc_base(tc_base), .tc_ref(tc_ref), .adc_data(adc_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_ch(s_out_ch), .tempc(s_tempc), .ovf(s_ovf), .dbg_state(s_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [31:0] base, input logic [7:0] rf,
                                input logic [15:0] adc, output logic [31:0] wrap,
                                output logic [31:0] sat, output logic o);
    longint b, corr, r;
    b    = longint'(signed'(base));
    corr = (longint'(rf) * longint'(rf) * longint'(adc[14:0])) / 64;
    r    = adc[15] ? (b - corr) : (b + corr);
    o    = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    wrap = r[31:0];
    sat  = o ? ((r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000) : wrap;
  endfunction

  // driver
  task automatic send(input logic [1:0] ch, input logic [31:0] base, input logic [7:0] rf,
                      input logic [15:0] adc);
    logic [31:0] w, s;
    logic o;
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
    end else begin
      in_valid = 1'b1;
      in_ch    = ch;
      tc_base  = base;
      tc_ref   = rf;
      adc_data = adc;
      @(posedge clk);
      #1;
      model(base, rf, adc, w, s, o);
      exp_q.push_back({32'(cyc), ch, o, s, w});
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) rise_cyc = cyc;
      prev_v = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("tempc", 64'(tempc), 64'(e[31:0]));
          chk("tempc_sat", 64'(s_tempc), 64'(e[63:32]));
          chk("ovf", 64'(ovf), 64'(e[64]));
          chk("ovf_sat", 64'(s_ovf), 64'(e[64]));
          chk("out_ch", 64'(out_ch), 64'(e[66:65]));
          chk("sat_valid", 64'(s_out_valid), 64'd1);
          chk("latency", 64'(rise_cyc - int'(e[98:67])), 64'(LAT));
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_tempc"}, 64'(tempc), 64'd0);
    chk({tag, "_out_ch"}, 64'(out_ch), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    logic [31:0] w, s;
    logic o;
    int n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // directed arithmetic cases
    send(2'd2, 32'd25, 8'd4, 16'h0040);
    drain();
    send(2'd0, 32'd25, 8'd4, 16'h8040);
    send(2'd1, 32'd5, 8'd4, 16'h8040);
    send(2'd3, 32'h7FFF_FFF0, 8'd255, 16'h7FFF);
    send(2'd0, 32'h8000_0005, 8'd255, 16'hFFFF);
    send(2'd1, -32'sd100, 8'd0, 16'h1234);
    send(2'd2, 32'd123, 8'd200, 16'h8000);
    send(2'd3, 32'd0, 8'd255, 16'h0000);
    drain();

    // backpressure: results held, new requests ignored
    rdy_fixed = 1'b0;
    send(2'd1, 32'd77, 8'd9, 16'h0123);
    model(32'd77, 8'd9, 16'h0123, w, s, o);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_wait_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_tempc", 64'(tempc), 64'(w));
      chk("bp_out_ch", 64'(out_ch), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'($urandom_range(0, 1));
      in_ch    = 2'($urandom);
      tc_base  = $urandom;
      tc_ref   = 8'($urandom);
      adc_data = 16'($urandom);
    end
    in_valid  = 1'b0;
    rdy_fixed = 1'b1;
    @(posedge clk);
    #2;
    chk("bp_release_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    chk("bp_after_valid", 64'(out_valid), 64'd0);
    chk("bp_after_in_ready", 64'(in_ready), 64'd1);
    drain();

    // reset in the middle of the magnitude pass
    send(2'd2, 32'd1000, 8'd50, 16'h0321);
    repeat (12) @(posedge clk);
    #1;
    chk("mid_state_mul", 64'(dbg_state), 64'd2);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_no_valid", 64'(out_valid), 64'd0);
    send(2'd2, -32'sd7, 8'd0, 16'h7FFF);
    drain();

    // back-to-back channels
    for (int c = 0; c < 4; c++) begin
      send(2'(c), 32'(c * 1000), 8'(c * 40 + 3), 16'(c * 3001));
    end
    drain();

    // random traffic with random backpressure
    rdy_mode = 1'b1;
    for (int k = 0; k < 30; k++) begin
      logic [31:0] b;
      case ($urandom_range(0, 3))
        0: b = 32'h7FFF_FFFF - 32'($urandom_range(0, 40000000));
        1: b = 32'h8000_0000 + 32'($urandom_range(0, 40000000));
        default: b = $urandom;
      endcase
      send(2'($urandom), b, 8'($urandom), 16'($urandom));
    end
    drain();
    rdy_mode = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL global_timeout: got running expected finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule
